// File: rtl/rns_pkg.sv
// Shared constants and types for the RNS stream converter.
//   MODULI : pairwise-coprime channel moduli, channel 0 first
//   RNS_M  : product of all moduli (dynamic range of the residue system)
//   RNS_MID: RNS_M/2, boundary between positive and negative encodings
//   CRT_A  : Chinese-remainder coefficients, derived from MODULI at elaboration
package rns_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned M_W    = 32;

  typedef logic [M_W-1:0] mword_t;

  typedef enum logic {
    MODE_FWD = 1'b0,
    MODE_REV = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_REV,
    ST_DONE
  } state_e;

  localparam mword_t MODULI [NUM_CH] = '{32'd255, 32'd254, 32'd253, 32'd251};
  localparam mword_t RNS_M   = 32'd4113089310;
  localparam mword_t RNS_MID = 32'd2056544655;

  // CRT_A[i] = (M/m_i) * ((M/m_i)^-1 mod m_i) mod M. The inverse is found by
  // exhaustive search, which is cheap because it only runs at elaboration.
  function automatic mword_t crt_coef(input int unsigned ch);
    longint unsigned m;
    longint unsigned mi;
    longint unsigned inv;
    m   = 64'(MODULI[ch]);
    mi  = 64'(RNS_M) / m;
    inv = 64'd0;
    for (longint unsigned k = 1; k < m; k++) begin
      if (((mi % m) * k) % m == 64'd1) inv = k;
    end
    return mword_t'((mi * inv) % 64'(RNS_M));
  endfunction

  localparam mword_t CRT_A [NUM_CH] = '{crt_coef(0), crt_coef(1), crt_coef(2), crt_coef(3)};

endpackage

// File: rtl/rns_mod_reduce.sv
// Combinational modular reduction r = x mod m for one channel.
//   x_i : dividend, full product width
//   m_i : modulus (a channel modulus or RNS_M)
//   r_o : remainder, always < m_i (0 if m_i is 0)
module rns_mod_reduce #(
  parameter int X_W = 40,
  parameter int M_W = 32
) (
  input  logic [X_W-1:0] x_i,
  input  logic [M_W-1:0] m_i,
  output logic [M_W-1:0] r_o
);

  always_comb begin
    r_o = '0;
    if (m_i != '0) r_o = M_W'(x_i % X_W'(m_i));
  end

endmodule

// File: rtl/rns_stream_convertor.sv
// Streaming converter between two's-complement integers and residue-number form.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake; mode selects FWD (int->RNS) or REV
//   int_in, rns_in       : operands, sampled only on the accepting edge
//   out_valid / out_ready: result handshake; results hold while stalled
//   int_out, rns_out, err: registered results, err flags an out-of-range operand
// One channel is processed per cycle through a single shared reducer.
module rns_stream_convertor
  import rns_pkg::*;
#(
  parameter int NUM_MOD = 4,
  parameter int MOD_W   = 8,
  parameter int INT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic [INT_W-1:0]         int_in,
  input  logic [NUM_MOD*MOD_W-1:0] rns_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INT_W-1:0]         int_out,
  output logic [NUM_MOD*MOD_W-1:0] rns_out,
  output logic                     err
);

  localparam int X_W   = MOD_W + M_W;
  localparam int IDX_W = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOD - 1);

  state_e                     state_q;
  mode_e                      mode_q;
  logic signed [INT_W-1:0]    op_q;
  logic [NUM_MOD*MOD_W-1:0]   rns_q;
  logic [NUM_MOD*MOD_W-1:0]   res_q;
  logic [IDX_W-1:0]           idx_q;
  mword_t                     acc_q;
  logic                       chan_err_q;
  logic                       out_valid_q;
  logic                       err_q;
  logic [INT_W-1:0]           int_out_q;
  logic [NUM_MOD*MOD_W-1:0]   rns_out_q;

  logic                       accept;
  mword_t                     mod_cur;
  mword_t                     crt_cur;
  logic [MOD_W-1:0]           r_cur;
  longint                     op_l;
  longint                     fwd_val;
  logic                       fwd_in_range;
  logic [X_W-1:0]             red_x;
  mword_t                     red_m;
  mword_t                     red_r;
  logic [NUM_MOD*MOD_W-1:0]   res_d;
  logic [M_W:0]               acc_sum;
  mword_t                     acc_d;
  logic                       chan_err_d;
  longint                     rev_signed;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign int_out   = int_out_q;
  assign rns_out   = rns_out_q;

  rns_mod_reduce #(
    .X_W (X_W),
    .M_W (M_W)
  ) u_reduce (
    .x_i (red_x),
    .m_i (red_m),
    .r_o (red_r)
  );

  // NOTE: every variable driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    mod_cur      = MODULI[idx_q];
    crt_cur      = CRT_A[idx_q];
    r_cur        = rns_q[int'(idx_q)*MOD_W +: MOD_W];
    op_l         = longint'(op_q);
    fwd_in_range = (op_l >= -longint'(RNS_MID)) && (op_l < longint'(RNS_MID));
    // Negative operands map onto the upper half of [0, M).
    fwd_val      = (op_l < 0) ? op_l + longint'(RNS_M) : op_l;

    red_x = X_W'(fwd_val);
    red_m = mod_cur;
    if (mode_q == MODE_REV) begin
      // Full-width product; reduction happens only after the multiply.
      red_x = X_W'(crt_cur) * X_W'(r_cur);
      red_m = RNS_M;
    end

    res_d = res_q;
    res_d[int'(idx_q)*MOD_W +: MOD_W] = MOD_W'(red_r);

    // Both addends are < M, so one conditional subtract keeps acc in [0, M).
    acc_sum = {1'b0, acc_q} + {1'b0, red_r};
    acc_d   = M_W'(acc_sum);
    if (acc_sum >= {1'b0, RNS_M}) acc_d = M_W'(acc_sum - {1'b0, RNS_M});

    chan_err_d = chan_err_q || (M_W'(r_cur) >= mod_cur);
    rev_signed = (acc_d >= RNS_MID) ? longint'(acc_d) - longint'(RNS_M) : longint'(acc_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_FWD;
      op_q        <= '0;
      rns_q       <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      chan_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      int_out_q   <= '0;
      rns_out_q   <= '0;
    end else if (accept) begin
      // Covers both IDLE and the zero-bubble DONE->FWD/REV hand-over.
      mode_q      <= mode_e'(mode);
      op_q        <= int_in;
      rns_q       <= rns_in;
      res_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      chan_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      state_q     <= (mode_e'(mode) == MODE_REV) ? ST_REV : ST_FWD;
    end else begin
      case (state_q)
        ST_FWD: begin
          res_q <= res_d;
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            err_q       <= !fwd_in_range;
            rns_out_q   <= fwd_in_range ? res_d : '0;
            int_out_q   <= '0;
          end
        end
        ST_REV: begin
          acc_q      <= acc_d;
          chan_err_q <= chan_err_d;
          idx_q      <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            err_q       <= chan_err_d;
            int_out_q   <= chan_err_d ? '0 : INT_W'(rev_signed);
            rns_out_q   <= '0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rns_stream_convertor.md
RNS_STREAM_CONVERTOR -- requirements
Module: rns_stream_convertor

Interface
REQ-001 SHALL have parameter NUM_MOD, default 4, number of residue channels.
REQ-002 SHALL have parameter MOD_W, default 8, bits per residue.
REQ-003 SHALL have parameter INT_W, default 32, two's-complement integer width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  converter accepts a request this cycle.
REQ-008 mode  input  1  0 = int->RNS (FWD), 1 = RNS->int (REV); sampled at acceptance.
REQ-009 int_in  input  INT_W  signed operand for FWD.
REQ-010 rns_in  input  NUM_MOD*MOD_W  residues for REV; channel i at bits [i*MOD_W +: MOD_W].
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 int_out  output  INT_W  signed REV result; 0 in FWD.
REQ-014 rns_out  output  NUM_MOD*MOD_W  FWD residues, same packing as rns_in; 0 in REV.
REQ-015 err  output  1  operand out of range; qualified by out_valid.

Function
REQ-016 SHALL be an FSM with states IDLE, FWD, REV and DONE.
REQ-017 in_ready SHALL be 1 in IDLE, out_ready in DONE, and 0 in FWD and REV.
REQ-018 On in_valid&&in_ready, SHALL latch mode and operand, clear the channel index and enter FWD or REV per mode.
REQ-019 FWD and REV SHALL each process one channel per cycle, index 0..NUM_MOD-1, then enter DONE; out_valid rises exactly NUM_MOD cycles after the accepting edge.
REQ-020 FWD: a negative operand SHALL be offset to v+RNS_M; residue i = v mod MODULI[i].
REQ-021 FWD: an operand outside [-RNS_MID, RNS_MID-1] SHALL set err=1 and drive rns_out=0.
REQ-022 REV: SHALL compute acc = (acc + (CRT_A[i]*r_i mod RNS_M)) per cycle, subtracting RNS_M once whenever acc >= RNS_M.
REQ-023 REV: the final acc >= RNS_MID SHALL output acc-RNS_M, else acc, sign-extended to INT_W.
REQ-024 REV: any r_i >= MODULI[i] SHALL set err=1 and drive int_out=0.
REQ-025 Intermediate products SHALL use full width (MOD_W + width of RNS_M) with no truncation before reduction.
REQ-026 In DONE, outputs SHALL hold stable until out_ready; out_valid&&!out_ready SHALL stall indefinitely.
REQ-027 In DONE, out_ready && !in_valid SHALL go to IDLE.
REQ-028 In DONE, out_ready && in_valid SHALL accept the new request that same cycle and go directly to FWD/REV (zero-bubble back-to-back).
REQ-029 Operand inputs SHALL be ignored outside the accepting cycle.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, index 0, acc 0, out_valid 0, err 0, int_out 0 and rns_out 0.
REQ-031 Reset mid-conversion SHALL discard the transaction with no result emitted.
REQ-032 in_ready SHALL be 1 from the first edge after reset release.

Structure
REQ-033 Package rns_pkg SHALL hold MODULI[], CRT_A[], RNS_M, RNS_MID and a mode enum.
REQ-034 Default MODULI SHALL be {255,254,253,251}, giving RNS_M=4113089310 and RNS_MID=2056544655.
REQ-035 CRT_A[i] SHALL equal (M/m_i)*((M/m_i)^-1 mod m_i) mod M.
REQ-036 One sub-module, rns_mod_reduce (combinational x mod m for one channel), SHALL be instantiated once and shared across cycles.

Verification
REQ-037 FWD int_in=100 -> rns_out channels {100,100,100,100}, err=0, out_valid 4 cycles after accept.
REQ-038 FWD int_in=-1 -> channels {254,253,252,250}; REV of that value -> int_out=-1 (0xFFFFFFFF).
REQ-039 FWD int_in=2056544655 -> err=1, rns_out=0; FWD int_in=-2056544655 -> err=0, and a REV round-trip returns the input.
REQ-040 REV with channel 0 residue = 255 -> err=1, int_out=0; all-zero residues -> int_out=0, err=0.
REQ-041 Hold out_ready=0 for 5 cycles -> outputs stable; then out_ready=1 with in_valid=1 -> new request accepted the same cycle, next result 4 cycles later.
REQ-042 Pull rst_n low at index 2 of REV -> outputs zero at once, no out_valid; the next request converts correctly.
